// File: rtl/exec_ctrl_pkg.sv
// Shared types and widths for the execution step controller.
//   exec_state_t : FSM state encoding, also driven onto the debug LEDs
//   STEP_CNT_W   : width of the executed-step counter
package exec_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        AUTO_RUN = 2'd1,
        MANUAL   = 2'd2,
        HALTED   = 2'd3
    } exec_state_t;

    localparam int unsigned STEP_CNT_W = 32;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw, bouncy push button into the clk domain and accepts a
// new level only after it has been stable for DEBOUNCE_CYCLES cycles.
// Ports:
//   clk       : system clock
//   rst       : synchronous, active-high reset
//   btn_raw   : raw asynchronous button input (active-high)
//   btn_level : debounced button level
//   btn_rise  : one-cycle pulse on a debounced 0->1 transition
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_sync;
    logic [CNT_W-1:0]       cnt;

    assign btn_sync = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= '0;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], btn_raw};
            btn_rise <= 1'b0;
            if (btn_sync == btn_level) begin
                // Any return to the accepted level restarts the stability window.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_level <= btn_sync;
                btn_rise  <= btn_sync;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/exec_step_controller.sv
// Generates the single-cycle CPU step enable from either the divided
// auto-step tick or a debounced manual step button, stops permanently on a
// CPU halt request and counts issued steps.
// Ports:
//   clk        : 50 MHz system clock
//   rst        : synchronous, active-high reset
//   tick_in    : divider output level; each rising edge is one auto step
//   btn_step   : raw manual step button (active-high, bouncy)
//   mode_auto  : 1 = auto stepping, 0 = manual stepping
//   halt       : CPU halt request, already in the clk domain
//   step_en    : registered one-cycle step enable to the CPU
//   step_count : number of step_en pulses since reset (wraps)
//   state_dbg  : current FSM state encoding for LEDs
module exec_step_controller
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  btn_step,
    input  logic                  mode_auto,
    input  logic                  halt,
    output logic                  step_en,
    output logic [STEP_CNT_W-1:0] step_count,
    output logic [1:0]            state_dbg
);

    logic [SYNC_STAGES-1:0] tick_sync;
    logic [SYNC_STAGES-1:0] tick_fill;
    logic                   tick_out;
    logic                   tick_d;
    logic                   tick_armed;
    logic                   tick_rise;
    logic [SYNC_STAGES-1:0] mode_sync;
    logic                   mode_s;
    logic                   btn_level;
    logic                   btn_rise;
    exec_state_t            state;
    logic [STEP_CNT_W-1:0]  count_q;

    assign tick_out   = tick_sync[SYNC_STAGES-1];
    assign mode_s     = mode_sync[SYNC_STAGES-1];
    assign step_count = count_q;
    assign state_dbg  = state;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_btn (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_step),
        .btn_level (btn_level),
        .btn_rise  (btn_rise)
    );

    // tick_fill marks when tick_out carries a real sample rather than reset
    // zeros; the edge detector only arms after a genuine low has been seen,
    // so a tick_in held high through reset never produces a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_sync  <= '0;
            tick_fill  <= '0;
            tick_d     <= 1'b0;
            tick_armed <= 1'b0;
            tick_rise  <= 1'b0;
            mode_sync  <= '0;
        end else begin
            tick_sync <= {tick_sync[SYNC_STAGES-2:0], tick_in};
            tick_fill <= {tick_fill[SYNC_STAGES-2:0], 1'b1};
            tick_d    <= tick_out;
            if (tick_fill[SYNC_STAGES-1] && !tick_out) begin
                tick_armed <= 1'b1;
            end
            tick_rise <= tick_armed & tick_out & ~tick_d;
            mode_sync <= {mode_sync[SYNC_STAGES-2:0], mode_auto};
        end
    end

    // Step events are only consumed when the state is not changing, so an
    // event coinciding with a mode switch or halt is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            step_en <= 1'b0;
            count_q <= '0;
        end else begin
            step_en <= 1'b0;
            if (halt) begin
                state <= HALTED;
            end else begin
                case (state)
                    IDLE: state <= mode_s ? AUTO_RUN : MANUAL;
                    AUTO_RUN: begin
                        if (!mode_s) begin
                            state <= MANUAL;
                        end else if (tick_rise) begin
                            step_en <= 1'b1;
                            count_q <= count_q + STEP_CNT_W'(1);
                        end
                    end
                    MANUAL: begin
                        if (mode_s) begin
                            state <= AUTO_RUN;
                        end else if (btn_rise) begin
                            step_en <= 1'b1;
                            count_q <= count_q + STEP_CNT_W'(1);
                        end
                    end
                    HALTED:  state <= HALTED;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/exec_step_controller.md
Name: exec_step_controller

Overview:
Consumes the slow toggling clock from the clock divider and a raw manual step button, and produces a one-cycle CPU step enable in the 50 MHz domain. The single-cycle RV32I core advances only on cycles where step_en=1. The block selects auto or manual stepping, stops permanently on a CPU halt request, and counts executed steps for the display.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles before the button level is accepted (20 ms at 50 MHz)
SYNC_STAGES, 2, flip-flop stages on each asynchronous or slow input (minimum 2)

Ports:
clk  input  1  50 MHz system clock
rst  input  1  synchronous, active-high reset
tick_in  input  1  divider output; a level, not a pulse; each rising edge = one auto step
btn_step  input  1  raw manual step button, active-high, bouncy
mode_auto  input  1  switch: 1 = auto stepping, 0 = manual stepping
halt  input  1  CPU halt request (e.g. ebreak retired); sampled in clk domain
step_en  output  1  single-cycle step enable to the CPU
step_count  output  32  number of step_en pulses issued since reset
state_dbg  output  2  current FSM state encoding, for LEDs

Behaviour:
- Reset (rst=1 at a clk edge): step_en=0, step_count=0, state=IDLE, all synchronizer flops=0, debounced level=0, debounce counter=0.
- tick_in, btn_step and mode_auto each pass through SYNC_STAGES flops. tick rise = sync_out & ~sync_out_d.
- Debouncer: the counter resets whenever the synced button equals the debounced level. Otherwise it increments. When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears. A debounced 0->1 transition is a 1-cycle btn_rise.
- FSM states:
  - IDLE=0: default after reset. mode_auto=1 -> AUTO_RUN; mode_auto=0 -> MANUAL.
  - AUTO_RUN=1: each tick rise issues step_en; mode_auto=0 -> MANUAL.
  - MANUAL=2: each btn_rise issues step_en; mode_auto=1 -> AUTO_RUN.
  - HALTED=3: reached from any state when halt=1; step_en is forced to 0; exited only by rst.
- step_en is registered. The event is detected at cycle N and step_en=1 at N+1, lasting exactly one cycle.
- Latency from tick_in rise to step_en: SYNC_STAGES+2 clk cycles (3 synchronizer/edge stages + output register at default).
- Events are ignored in states that do not consume them: btn_rise in AUTO_RUN, tick rise in MANUAL.
- Mode change cycle: any event arriving in the same cycle as the state change is discarded. There is no queueing.
- Simultaneous events:
  - halt and a step event in the same cycle: halt wins; no step_en; go to HALTED.
  - halt while step_en=1 is already registered: that pulse completes; no further pulses.
- step_count increments on the cycle step_en=1 and wraps from 0xFFFF_FFFF to 0.
- Reset mid-operation: any pending step_en is cancelled the following cycle; the debounce state is lost.
- An IDLE->AUTO_RUN transition does not fabricate a step from tick_in already high. The edge detector requires an actual 0->1 transition after reset.

Decomposition:
- Package exec_ctrl_pkg holds:
  - typedef enum logic [1:0] exec_state_t {IDLE, AUTO_RUN, MANUAL, HALTED}
  - localparam STEP_CNT_W = 32
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, btn_level, btn_rise) contains the synchronizer and the debounce counter. It is reusable for the board's other buttons.
- The top level holds the tick synchronizer/edge detector, the FSM, the step_en register and step_count.

Test Plan:
1. DEBOUNCE_CYCLES=4, mode_auto=1, toggle tick_in every 10 cycles for 100 cycles -> 5 step_en pulses, each 1 cycle wide, each 4 cycles after its tick rise; step_count=5.
2. mode_auto=0; btn_step bounces 1,0,1,0 for 1 cycle each, then holds 1 for 10 cycles -> exactly 1 step_en, issued 7 cycles after the stable high begins (2 sync + 4 debounce + 1 register); step_count=1.
3. AUTO_RUN; assert halt in the same cycle as a tick rise -> no step_en; state_dbg=3; further ticks and button presses produce nothing for 200 cycles.
4. In MANUAL, press the button (debounced) while tick_in toggles -> only button steps counted; switch mode_auto=1 -> tick steps resume and button steps are ignored.
5. Preload step_count=0xFFFF_FFFF via force, issue one step -> step_count=0.
6. Assert rst for 1 cycle while step_en=1 and tick_in is held high -> next cycle: step_en=0, step_count=0, state_dbg=0; no step until tick_in falls and rises again.
